// File: rtl/cmac_prod_accum.sv
// CMAC product accumulator: lane reduction, group accumulation with
// saturation, and one valid/ready result per in_last-terminated group.
module cmac_prod_accum #(
  parameter int NUM_MUL = 8,
  parameter int ACC_W   = 48,
  parameter int CNT_W   = 16
) (
  input  logic                   nvdla_core_clk,
  input  logic                   nvdla_core_rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NUM_MUL*32-1:0]  in_prod,
  input  logic [NUM_MUL-1:0]     in_mask,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_W-1:0]       out_sum,
  output logic                   out_ovf,
  output logic [CNT_W-1:0]       out_cnt
);

  // Beat sum is kept exact at its own width so a narrow ACC_W only
  // saturates in the accumulate step, never wraps in the reduction.
  localparam int LW = $clog2(NUM_MUL);
  localparam int SW = 33 + LW;
  localparam int MW = (ACC_W > SW) ? ACC_W : SW;
  localparam int TW = MW + 1;

  localparam logic [ACC_W-1:0] MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic              adv;
  logic [SW-1:0]     lane_sum;

  logic              s1_valid;
  logic              s1_last;
  logic [SW-1:0]     s1_sum;

  logic [ACC_W-1:0]  acc;
  logic              ovf;
  logic [CNT_W-1:0]  cnt;
  logic              first;

  logic [TW-1:0]     base;
  logic [TW-1:0]     addend;
  logic [TW-1:0]     t;
  logic              in_range;
  logic [ACC_W-1:0]  acc_nxt;
  logic              ovf_nxt;
  logic [CNT_W-1:0]  cnt_nxt;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < NUM_MUL; i++) begin
      if (in_mask[i]) begin
        lane_sum = lane_sum
                 + {{(SW-32){in_prod[32*i+31]}},
                    in_prod[32*i +: 32]};
      end
    end
  end

  always_comb begin
    base     = first ? '0
             : {{(TW-ACC_W){acc[ACC_W-1]}}, acc};
    addend   = {{(TW-SW){s1_sum[SW-1]}}, s1_sum};
    t        = base + addend;
    in_range = (&t[TW-1:ACC_W-1]) | ~(|t[TW-1:ACC_W-1]);
    acc_nxt  = t[ACC_W-1:0];
    if (!in_range) begin
      acc_nxt = t[TW-1] ? MIN : MAX;
    end
    ovf_nxt  = ovf | ~in_range;
    cnt_nxt  = first ? CNT_W'(1) : cnt + CNT_W'(1);
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s1_sum    <= '0;
      acc       <= '0;
      ovf       <= 1'b0;
      cnt       <= '0;
      first     <= 1'b1;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
      out_cnt   <= '0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_last  <= in_last;
      s1_sum   <= lane_sum;
      if (s1_valid) begin
        acc   <= acc_nxt;
        cnt   <= cnt_nxt;
        first <= s1_last;
        ovf   <= s1_last ? 1'b0 : ovf_nxt;
      end
      if (s1_valid && s1_last) begin
        out_valid <= 1'b1;
        out_sum   <= acc_nxt;
        out_ovf   <= ovf_nxt;
        out_cnt   <= cnt_nxt;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
